tri_issue_queue: RTL and testbench
==================================

// Module: tri_issue_queue
// PURPOSE
//  Buffers setup-complete triangles from the AXI register front end and issues them one at a time to the rasterizer.
//  Uses the rasterizer's triangle_valid / triangle_ready / rasterizer_done protocol.
//  Computes signed 2*area per triangle; drops degenerate (area 0) and culled (back-face) triangles before queuing.
//  Parametrised in coordinate/depth widths and queue depth. Sits between the AXI controller and the rasterizer.
// PARAMETERS
//  X_W      10   screen X coordinate width (unsigned)
//  Y_W      9    screen Y coordinate width (unsigned)
//  Z_W      16   per-vertex depth width
//  COLOR_W  8    colour width (RGB332 at default)
//  INV_W    32   inverse-area width (8.24 fixed point at default), passed through untouched
//  DEPTH    8    queue entries, power of two, >=2
// PORTS
//  axi_aclk        in   1                clock
//  axi_reset       in   1                synchronous, active-high reset
//  in_valid        in   1                producer offers a triangle
//  in_ready        out  1                block accepts; transfer occurs when in_valid && in_ready
//  in_tri          in   $bits(tri_t)     {v1x,v1y,v2x,v2y,v3x,v3y,z1,z2,z3,color,inv_area}
//  cull_mode       in   2                00 none, 01 cull area2<0, 10 cull area2>0, 11 none; sampled at S1
//  flush           in   1                discard S1 and all queued entries (in-flight triangle unaffected)
//  triangle_valid  out  1                one-cycle issue pulse to rasterizer
//  triangle_out    out  $bits(tri_t)     stable from issue until rasterizer_done
//  triangle_ready  in   1                rasterizer idle
//  rasterizer_done in   1                rasterizer finished current triangle
//  busy            out  1                entry in S1, queue non-empty, or triangle in flight
//  q_count         out  $clog2(DEPTH)+1  queued entries
//  drop_count      out  16               degenerate+culled total, saturating
//  issue_count     out  16               triangles issued, wrapping
// BEHAVIOUR
//  Reset: in_ready=0 during reset, 1 the cycle after. All other outputs 0; FSM=IDLE; S1 and queue empty.
//  S1 stage: accepted triangle registered with
//    area2 = x1*(y2-y3)+x2*(y3-y1)+x3*(y1-y2), signed, X_W+Y_W+3 bits, no truncation.
//  Next cycle: S1 entry is dropped (drop_count+1) if area2==0 or culled per cull_mode; otherwise written to queue.
//  in_ready = (q_count + s1_valid) < DEPTH. The queue can never overflow; S1 never stalls.
//  Issue FSM:
//    IDLE -> ISSUE when queue non-empty && triangle_ready.
//    ISSUE (1 cycle): triangle_valid=1, pop head into triangle_out, issue_count+1 -> BUSY.
//    BUSY -> IDLE on rasterizer_done. triangle_ready is ignored in BUSY.
//  Minimum issue-to-issue spacing is 3 cycles.
//  Latency: with empty queue, an idle rasterizer and accept at cycle 0, triangle_valid pulses at cycle 3.
//  Simultaneous S1 write and ISSUE pop: both occur; q_count unchanged. Write into an empty queue is visible to IDLE the following cycle.
//  flush: clears S1 and the queue the same cycle. Any in_valid that cycle is not accepted (in_ready forced 0).
//    BUSY/ISSUE continue to completion. Counters are not cleared.
//  rasterizer_done in IDLE/ISSUE is ignored.
//  Reset mid-BUSY: return to IDLE; the rasterizer must be reset alongside.
//  drop_count saturates at 16'hFFFF; issue_count wraps.
// STRUCTURE
//  tri_pkg: tri_t packed struct (param widths via package localparams), cull_mode_e, AREA_W localparam.
//  Sub-module tri_fifo: synchronous FIFO (DEPTH x $bits(tri_t)), push/pop/count/full/empty, same-cycle push+pop on full/empty legal.
//  Top holds S1 area/cull logic, issue FSM, counters.
// TESTING
//  T1 accept (40,20),(140,120),(40,120) color E0, mode 00 -> area2=+10000; triangle_valid at cycle 3; triangle_out matches input; issue_count=1.
//  T2 (140,20),(90,70),(190,70) area2=-5000, mode 01 -> dropped, drop_count=1, no triangle_valid; mode 10 -> issued.
//  T3 (10,10),(20,20),(30,30) any mode -> area2=0, dropped, q_count stays 0.
//  T4 triangle_ready=1, rasterizer_done withheld, push 9 valid triangles back-to-back -> 1 in flight + 8 queued, in_ready=0.
//     Pulse done 9 times -> 9 issues in FIFO order, spacing >=3 cycles.
//  T5 queue holds 5, BUSY: assert flush -> q_count=0 next cycle, in-flight completes on done, no further issue, busy=0.
//  T6 assert axi_reset while BUSY with 3 queued -> next cycle all outputs 0; a fresh triangle is issued at cycle 3 after accept.

Source files
------------

// File: rtl/tri_pkg.sv
// Shared triangle payload, cull modes and signed-area helpers for the triangle issue path.
package tri_pkg;

   localparam int unsigned X_W     = 10;
   localparam int unsigned Y_W     = 9;
   localparam int unsigned Z_W     = 16;
   localparam int unsigned COLOR_W = 8;
   localparam int unsigned INV_W   = 32;
   localparam int unsigned AREA_W  = X_W + Y_W + 3;

   typedef struct packed {
      logic [X_W-1:0]     v1x;
      logic [Y_W-1:0]     v1y;
      logic [X_W-1:0]     v2x;
      logic [Y_W-1:0]     v2y;
      logic [X_W-1:0]     v3x;
      logic [Y_W-1:0]     v3y;
      logic [Z_W-1:0]     z1;
      logic [Z_W-1:0]     z2;
      logic [Z_W-1:0]     z3;
      logic [COLOR_W-1:0] color;
      logic [INV_W-1:0]   inv_area;
   } tri_t;

   localparam int unsigned TRI_W = $bits(tri_t);

   typedef enum logic [1:0] {
      CULL_OFF     = 2'b00,
      CULL_NEG     = 2'b01,
      CULL_POS     = 2'b10,
      CULL_OFF_ALT = 2'b11
   } cull_mode_e;

   // Twice the signed area; AREA_W holds the full range so nothing wraps.
   function automatic logic signed [AREA_W-1:0] calc_area2(input tri_t t);
      logic signed [AREA_W-1:0] x1, x2, x3, y1, y2, y3;
      x1 = AREA_W'(t.v1x);
      x2 = AREA_W'(t.v2x);
      x3 = AREA_W'(t.v3x);
      y1 = AREA_W'(t.v1y);
      y2 = AREA_W'(t.v2y);
      y3 = AREA_W'(t.v3y);
      return x1 * (y2 - y3) + x2 * (y3 - y1) + x3 * (y1 - y2);
   endfunction

   function automatic logic cull_drop(input logic signed [AREA_W-1:0] area2,
                                      input cull_mode_e mode);
      logic zero;
      logic neg;
      zero = (area2 == '0);
      neg  = area2[AREA_W-1];
      return zero | ((mode == CULL_NEG) & neg) | ((mode == CULL_POS) & ~neg & ~zero);
   endfunction

endpackage

// File: rtl/tri_fifo.sv
// Synchronous FIFO with occupancy count; push on full is accepted when a pop frees the slot.
module tri_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push && !clr) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/tri_issue_queue.sv
// Area/cull stage, triangle queue and one-at-a-time issue to the rasterizer.
module tri_issue_queue
   import tri_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic                   axi_aclk,
   input  logic                   axi_reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [TRI_W-1:0]       in_tri,
   input  logic [1:0]             cull_mode,
   input  logic                   flush,
   output logic                   triangle_valid,
   output logic [TRI_W-1:0]       triangle_out,
   input  logic                   triangle_ready,
   input  logic                   rasterizer_done,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] q_count,
   output logic [15:0]            drop_count,
   output logic [15:0]            issue_count
);

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_e;

   state_e                   state;
   logic                     ready_q;
   logic                     s1_valid;
   tri_t                     s1_tri;
   logic signed [AREA_W-1:0] s1_area;
   cull_mode_e               s1_mode;

   logic             accept;
   logic             s1_drop;
   logic             fifo_push;
   logic             fifo_push_ok;
   logic             fifo_pop;
   logic             fifo_full;
   logic             fifo_empty;
   tri_t             fifo_dout;
   logic [CNT_W-1:0] count_nxt;

   assign in_ready     = ready_q & ~flush;
   assign accept       = in_valid & in_ready;
   assign s1_drop      = s1_valid & cull_drop(s1_area, s1_mode);
   assign fifo_push    = s1_valid & ~s1_drop & ~flush;
   assign fifo_pop     = (state == IDLE) & ~fifo_empty & triangle_ready & ~flush;
   assign fifo_push_ok = fifo_push & (~fifo_full | fifo_pop);
   assign count_nxt    = flush ? '0 : q_count + CNT_W'(fifo_push_ok) - CNT_W'(fifo_pop);
   assign busy         = s1_valid | ~fifo_empty | (state != IDLE);

   // in_ready reserves a queue slot for whatever is sitting in S1, so S1 never stalls.
   always_ff @(posedge axi_aclk) begin
      if (axi_reset) begin
         ready_q    <= 1'b0;
         s1_valid   <= 1'b0;
         s1_tri     <= '0;
         s1_area    <= '0;
         s1_mode    <= CULL_OFF;
         drop_count <= '0;
      end else begin
         ready_q  <= (count_nxt + CNT_W'(accept)) < CNT_W'(DEPTH);
         s1_valid <= accept;
         if (accept) begin
            s1_tri  <= tri_t'(in_tri);
            s1_area <= calc_area2(tri_t'(in_tri));
            s1_mode <= cull_mode_e'(cull_mode);
         end
         if (s1_drop && !flush && drop_count != 16'hFFFF) begin
            drop_count <= drop_count + 16'd1;
         end
      end
   end

   tri_fifo #(
      .WIDTH (TRI_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (axi_aclk),
      .rst   (axi_reset),
      .clr   (flush),
      .push  (fifo_push),
      .din   (s1_tri),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .count (q_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Head is popped on the IDLE->ISSUE edge, so triangle_valid is high exactly while in ISSUE.
   always_ff @(posedge axi_aclk) begin
      if (axi_reset) begin
         state          <= IDLE;
         triangle_valid <= 1'b0;
         triangle_out   <= '0;
         issue_count    <= '0;
      end else begin
         triangle_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (fifo_pop) begin
                  state          <= ISSUE;
                  triangle_valid <= 1'b1;
                  triangle_out   <= fifo_dout;
                  issue_count    <= issue_count + 16'd1;
               end
            end
            ISSUE: state <= BUSY;
            BUSY: begin
               if (rasterizer_done) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tri_issue_queue.sv
// Scoreboard bench for tri_issue_queue: directed scenarios followed by randomized traffic.
module tb_tri_issue_queue;
   import tri_pkg::*;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             axi_reset;
   logic             in_valid;
   logic             in_ready;
   logic [TRI_W-1:0] in_tri;
   logic [1:0]       cull_mode;
   logic             flush;
   logic             triangle_valid;
   logic [TRI_W-1:0] triangle_out;
   logic             triangle_ready;
   logic             rasterizer_done;
   logic             busy;
   logic [CNT_W-1:0] q_count;
   logic [15:0]      drop_count;
   logic [15:0]      issue_count;

   int   checks = 0;
   int   passed = 0;
   int   cyc = 0;
   tri_t exp_q[$];
   int   exp_pushed = 0;
   int   exp_drop = 0;
   int   done_req = 0;
   int   done_ack = 0;
   bit   auto_done = 1'b0;
   bit   rand_ready = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   tri_issue_queue #(.DEPTH(DEPTH)) dut (
      .axi_aclk        (clk),
      .axi_reset       (axi_reset),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_tri          (in_tri),
      .cull_mode       (cull_mode),
      .flush           (flush),
      .triangle_valid  (triangle_valid),
      .triangle_out    (triangle_out),
      .triangle_ready  (triangle_ready),
      .rasterizer_done (rasterizer_done),
      .busy            (busy),
      .q_count         (q_count),
      .drop_count      (drop_count),
      .issue_count     (issue_count)
   );

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: twice the signed area from the shoelace formula, in plain integers.
   function automatic int area_of(input tri_t t);
      int x1, y1, x2, y2, x3, y3;
      x1 = int'(t.v1x); y1 = int'(t.v1y);
      x2 = int'(t.v2x); y2 = int'(t.v2y);
      x3 = int'(t.v3x); y3 = int'(t.v3y);
      return x1 * (y2 - y3) + x2 * (y3 - y1) + x3 * (y1 - y2);
   endfunction

   function automatic bit model_drop(input tri_t t, input logic [1:0] m);
      int a;
      a = area_of(t);
      if (a == 0) return 1'b1;
      if (m == 2'b01 && a < 0) return 1'b1;
      if (m == 2'b10 && a > 0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic tri_t mk_tri(input int x1, input int y1, input int x2, input int y2,
                                   input int x3, input int y3, input int col);
      tri_t t;
      t.v1x = X_W'(x1); t.v1y = Y_W'(y1);
      t.v2x = X_W'(x2); t.v2y = Y_W'(y2);
      t.v3x = X_W'(x3); t.v3y = Y_W'(y3);
      t.z1 = Z_W'($urandom); t.z2 = Z_W'($urandom); t.z3 = Z_W'($urandom);
      t.color = COLOR_W'(col);
      t.inv_area = INV_W'($urandom);
      return t;
   endfunction

   function automatic tri_t rand_tri(input int degen_pct);
      tri_t t;
      t = mk_tri(int'($urandom_range(0, 1023)), int'($urandom_range(0, 511)),
                 int'($urandom_range(0, 1023)), int'($urandom_range(0, 511)),
                 int'($urandom_range(0, 1023)), int'($urandom_range(0, 511)),
                 int'($urandom_range(0, 255)));
      if (int'($urandom_range(0, 99)) < degen_pct) begin
         t.v3x = t.v2x;
         t.v3y = t.v2y;
      end
      return t;
   endfunction

   function automatic tri_t valid_tri();
      tri_t t;
      do t = rand_tri(0); while (area_of(t) == 0);
      return t;
   endfunction

   task automatic send(input tri_t t, input logic [1:0] m);
      bit ok;
      ok = 1'b0;
      in_tri = t;
      cull_mode = m;
      in_valid = 1'b1;
      for (int i = 0; i < 200 && !ok; i++) begin
         if (in_ready) begin
            ok = 1'b1;
            if (model_drop(t, m)) exp_drop++;
            else begin
               exp_q.push_back(t);
               exp_pushed++;
            end
         end
         tick();
      end
      in_valid = 1'b0;
      if (!ok) begin
         checks++;
         $display("FAIL send_timeout: in_ready stayed 0, expected 1");
      end
   endtask

   task automatic pulse_done();
      done_req++;
      tick();
      tick();
   endtask

   task automatic wait_issue(input string name, input int bound);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < bound; i++) begin
         if (triangle_valid) begin
            seen = 1'b1;
            break;
         end
         tick();
      end
      check(name, 160'(seen), 160'(1));
   endtask

   // Rasterizer model: manual done requests, or automatic done 0..3 cycles into BUSY.
   initial begin
      bit tv;
      bit pend;
      int cnt;
      int req_seen;
      rasterizer_done = 1'b0;
      pend = 1'b0;
      cnt = 0;
      forever begin
         @(posedge clk);
         tv = triangle_valid;
         req_seen = done_req;
         #1;
         rasterizer_done = 1'b0;
         if (req_seen != done_ack) begin
            done_ack++;
            rasterizer_done = 1'b1;
         end else if (auto_done) begin
            if (tv) begin
               pend = 1'b1;
               cnt = int'($urandom_range(0, 3));
            end
            if (pend) begin
               if (cnt == 0) begin
                  rasterizer_done = 1'b1;
                  pend = 1'b0;
               end else cnt--;
            end
         end
      end
   end

   initial begin
      triangle_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         triangle_ready = rand_ready ? ($urandom_range(0, 9) < 7) : 1'b1;
      end
   end

   // Monitor: every issue pulse must match the oldest surviving triangle, spaced >= 3 cycles.
   initial begin
      int last;
      last = -1000;
      forever begin
         @(negedge clk);
         if (axi_reset) last = -1000;
         else if (triangle_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL unexpected_issue: got triangle %0h, expected none", triangle_out);
            end else begin
               tri_t e;
               e = exp_q.pop_front();
               check("triangle_out", 160'(triangle_out), 160'(e));
            end
            check("issue_spacing", 160'((cyc - last) >= 3), 160'(1));
            last = cyc;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      tri_t t;
      bit drained;
      axi_reset = 1'b1;
      in_valid = 1'b0;
      in_tri = '0;
      cull_mode = 2'b00;
      flush = 1'b0;
      tick();
      tick();
      check("rst_in_ready", 160'(in_ready), 160'(0));
      check("rst_valid", 160'(triangle_valid), 160'(0));
      check("rst_q_count", 160'(q_count), 160'(0));
      check("rst_drop", 160'(drop_count), 160'(0));
      check("rst_issue", 160'(issue_count), 160'(0));
      check("rst_busy", 160'(busy), 160'(0));
      axi_reset = 1'b0;
      tick();
      check("in_ready_after_rst", 160'(in_ready), 160'(1));

      // T1: positive area, no culling, latency 3
      t = mk_tri(40, 20, 140, 120, 40, 120, 8'hE0);
      send(t, 2'b00);
      check("t1_valid_c1", 160'(triangle_valid), 160'(0));
      tick();
      check("t1_valid_c2", 160'(triangle_valid), 160'(0));
      tick();
      check("t1_valid_c3", 160'(triangle_valid), 160'(1));
      check("t1_issue_count", 160'(issue_count), 160'(1));
      check("t1_busy", 160'(busy), 160'(1));
      tick();
      pulse_done();
      check("t1_idle", 160'(busy), 160'(0));

      // T2: negative area culled in mode 01, issued in mode 10
      t = mk_tri(140, 20, 90, 70, 190, 70, 8'h1C);
      send(t, 2'b01);
      tick(); tick(); tick();
      check("t2_drop", 160'(drop_count), 160'(1));
      check("t2_q_count", 160'(q_count), 160'(0));
      check("t2_no_issue", 160'(issue_count), 160'(1));
      send(t, 2'b10);
      wait_issue("t2_issue_mode10", 10);
      check("t2_issue_count", 160'(issue_count), 160'(2));
      tick();
      pulse_done();

      // T3: degenerate triangle dropped in every mode
      t = mk_tri(10, 10, 20, 20, 30, 30, 8'h03);
      for (int m = 0; m < 4; m++) begin
         send(t, 2'(m));
         check("t3_q_count", 160'(q_count), 160'(0));
      end
      tick(); tick();
      check("t3_q_count_end", 160'(q_count), 160'(0));
      check("t3_drop", 160'(drop_count), 160'(5));

      // T4: fill the queue behind an in-flight triangle, then drain in order
      for (int i = 0; i < 9; i++) send(valid_tri(), 2'b00);
      tick(); tick(); tick();
      check("t4_q_full", 160'(q_count), 160'(DEPTH));
      check("t4_in_ready", 160'(in_ready), 160'(0));
      check("t4_issue_count", 160'(issue_count), 160'(3));
      for (int k = 0; k < 9; k++) begin
         pulse_done();
         if (k < 8) begin
            wait_issue("t4_issue", 10);
            tick();
         end
      end
      check("t4_issue_end", 160'(issue_count), 160'(11));
      check("t4_q_empty", 160'(q_count), 160'(0));
      check("t4_idle", 160'(busy), 160'(0));

      // T5: flush while busy with 5 queued
      for (int i = 0; i < 6; i++) send(valid_tri(), 2'b00);
      tick(); tick(); tick(); tick();
      check("t5_q_count", 160'(q_count), 160'(5));
      in_tri = valid_tri();
      cull_mode = 2'b00;
      in_valid = 1'b1;
      flush = 1'b1;
      #1;
      check("t5_flush_in_ready", 160'(in_ready), 160'(0));
      @(posedge clk);
      #1;
      flush = 1'b0;
      in_valid = 1'b0;
      exp_pushed -= exp_q.size();
      exp_q.delete();
      check("t5_q_flushed", 160'(q_count), 160'(0));
      check("t5_inflight_busy", 160'(busy), 160'(1));
      pulse_done();
      tick(); tick(); tick(); tick();
      check("t5_idle", 160'(busy), 160'(0));
      check("t5_issue_count", 160'(issue_count), 160'(12));

      // T6: reset while busy with 3 queued
      for (int i = 0; i < 4; i++) send(valid_tri(), 2'b00);
      tick(); tick(); tick(); tick();
      check("t6_q_count", 160'(q_count), 160'(3));
      axi_reset = 1'b1;
      tick();
      exp_q.delete();
      exp_pushed = 0;
      exp_drop = 0;
      check("t6_valid", 160'(triangle_valid), 160'(0));
      check("t6_q_count_rst", 160'(q_count), 160'(0));
      check("t6_drop", 160'(drop_count), 160'(0));
      check("t6_issue", 160'(issue_count), 160'(0));
      check("t6_busy", 160'(busy), 160'(0));
      check("t6_in_ready", 160'(in_ready), 160'(0));
      axi_reset = 1'b0;
      tick();
      send(valid_tri(), 2'b00);
      tick();
      check("t6_valid_c2", 160'(triangle_valid), 160'(0));
      tick();
      check("t6_valid_c3", 160'(triangle_valid), 160'(1));
      check("t6_issue_count", 160'(issue_count), 160'(1));
      tick();
      pulse_done();

      // Randomized traffic against the reference model
      auto_done = 1'b1;
      rand_ready = 1'b1;
      for (int i = 0; i < 150; i++) begin
         send(rand_tri(15), 2'($urandom_range(0, 3)));
         for (int g = int'($urandom_range(0, 2)); g > 0; g--) tick();
      end
      drained = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (exp_q.size() == 0 && !busy) begin
            drained = 1'b1;
            break;
         end
         tick();
      end
      check("rand_drained", 160'(drained), 160'(1));
      check("rand_drop_count", 160'(drop_count), 160'(exp_drop));
      check("rand_issue_count", 160'(issue_count), 160'(exp_pushed));

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
